// File: rtl/ham1511_scrub_ctrl_if.sv
// ham1511_scrub_ctrl_if: memory-port request/grant bus between scrubber and arbiter.
`timescale 1ns/1ps
interface ham1511_scrub_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              mem_req;
    logic              mem_we;
    logic              mem_grant;
    logic [ADDR_W-1:0] mem_addr;
    logic [14:0]       mem_wdata;
    logic [14:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_grant, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_grant, mem_rdata
    );
endinterface

// File: rtl/ham1511_scrub_ctrl.sv
// ham1511_scrub_ctrl: background scrubber for Hamming(15,11) memory, writes back corrected words.
// Optional error-location log enabled by defining SCRUB_ERR_LOG_EN.
`timescale 1ns/1ps
module ham1511_scrub_ctrl #(
    parameter int ADDR_W   = 8,
    parameter int INTERVAL = 1024,
    parameter int CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ham1511_scrub_ctrl_if.master  mem,
    input  logic                  enable_i,
    output logic [14:0]           dec_cw_o,
    input  logic [10:0]           dec_data_i,
    input  logic [3:0]            dec_syn_i,
    output logic [10:0]           enc_data_o,
    input  logic [14:0]           enc_cw_i,
    output logic                  busy_o,
    output logic                  pass_done_o,
    output logic [CNT_W-1:0]      corr_cnt_o
`ifdef SCRUB_ERR_LOG_EN
   ,output logic [ADDR_W-1:0]     err_addr_o,
    output logic [3:0]            err_syn_o,
    output logic                  err_valid_o
`endif
);
    localparam int CW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;

    typedef enum logic [2:0] {IDLE, WAIT, RD_REQ, RD_DATA, CHECK, WR_REQ, NEXT} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [14:0]       cw_q, cw_d;
    logic [10:0]       enc_q, enc_d;
    logic [CNT_W-1:0]  corr_q, corr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            cw_q    <= '0;
            enc_q   <= '0;
            corr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            cw_q    <= cw_d;
            enc_q   <= enc_d;
            corr_q  <= corr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        cw_d    = cw_q;
        enc_d   = enc_q;
        corr_d  = corr_q;
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    cnt_d   = CW'(INTERVAL - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!enable_i)
                    state_d = IDLE;
                else if (cnt_q == '0)
                    state_d = RD_REQ;
                else
                    cnt_d = cnt_q - 1'b1;
            end
            RD_REQ:  state_d = mem.mem_grant ? RD_DATA : RD_REQ;
            RD_DATA: begin
                cw_d    = mem.mem_rdata;
                state_d = CHECK;
            end
            CHECK: begin
                // every non-zero syndrome is a correctable single-bit error at (15,11)
                if (dec_syn_i != 4'd0) begin
                    enc_d   = dec_data_i;
                    corr_d  = (&corr_q) ? corr_q : corr_q + 1'b1;
                    state_d = WR_REQ;
                end else begin
                    state_d = NEXT;
                end
            end
            WR_REQ:  state_d = mem.mem_grant ? NEXT : WR_REQ;
            NEXT: begin
                addr_d  = addr_q + 1'b1;
                cnt_d   = CW'(INTERVAL - 1);
                state_d = enable_i ? WAIT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem.mem_req   = (state_q == RD_REQ) || (state_q == WR_REQ);
    assign mem.mem_we    = (state_q == WR_REQ);
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = (state_q == WR_REQ) ? enc_cw_i : 15'd0;
    assign dec_cw_o      = cw_q;
    assign enc_data_o    = enc_q;
    assign busy_o        = (state_q != IDLE) && (state_q != WAIT);
    assign pass_done_o   = (state_q == NEXT) && (&addr_q);
    assign corr_cnt_o    = corr_q;

`ifdef SCRUB_ERR_LOG_EN
    logic [ADDR_W-1:0] err_addr_q;
    logic [3:0]        err_syn_q;
    logic              err_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_addr_q  <= '0;
            err_syn_q   <= '0;
            err_valid_q <= 1'b0;
        end else if (state_q == CHECK && dec_syn_i != 4'd0) begin
            err_addr_q  <= addr_q;
            err_syn_q   <= dec_syn_i;
            err_valid_q <= 1'b1;
        end
    end

    assign err_addr_o  = err_addr_q;
    assign err_syn_o   = err_syn_q;
    assign err_valid_o = err_valid_q;
`endif
endmodule

// File: tb/tb_ham1511_scrub_ctrl.sv
// tb_ham1511_scrub_ctrl: scoreboard bench with memory and Hamming(15,11) codec models.
`timescale 1ns/1ps
module tb_ham1511_scrub_ctrl;
    localparam int AW = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [14:0] dec_cw;
    logic [10:0] dec_data;
    logic [3:0]  dec_syn;
    logic [10:0] enc_data;
    logic [14:0] enc_cw;
    logic        busy, pass_done;
    logic [1:0]  corr_cnt;

    logic        grant = 1'b1;
    logic [14:0] rdata = '0;
    logic [14:0] mem [4];
    logic        load = 1'b0, inj = 1'b0;
    logic [1:0]  inj_a = '0;
    logic [14:0] inj_m = '0;

    typedef struct packed {logic we; logic [1:0] a; logic [14:0] d;} txn_t;
    txn_t q[$];
    int   errors = 0, checks = 0, pd_cnt = 0;
    logic [1:0] last_rd = '0;

    ham1511_scrub_ctrl_if #(.ADDR_W(AW)) mif();

    ham1511_scrub_ctrl #(.ADDR_W(AW), .INTERVAL(4), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .mem(mif.master), .enable_i(enable),
        .dec_cw_o(dec_cw), .dec_data_i(dec_data), .dec_syn_i(dec_syn),
        .enc_data_o(enc_data), .enc_cw_i(enc_cw), .busy_o(busy),
        .pass_done_o(pass_done), .corr_cnt_o(corr_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] enc(input logic [10:0] d);
        logic [14:0] c;
        logic x;
        int k;
        c = '0;
        k = 0;
        for (int p = 1; p <= 15; p++)
            if ((p & (p - 1)) != 0) begin c[p-1] = d[k]; k++; end
        for (int b = 0; b < 4; b++) begin
            x = 1'b0;
            for (int p = 1; p <= 15; p++) if (((p >> b) & 1) == 1) x ^= c[p-1];
            c[(1 << b) - 1] = x;
        end
        return c;
    endfunction

    function automatic logic [3:0] syn(input logic [14:0] c);
        logic [3:0] s;
        s = '0;
        for (int p = 1; p <= 15; p++) if (c[p-1]) s ^= 4'(p);
        return s;
    endfunction

    function automatic logic [10:0] ext(input logic [14:0] cin);
        logic [14:0] c;
        logic [3:0]  s;
        logic [10:0] d;
        int k;
        c = cin;
        s = syn(c);
        if (s != 4'd0) c[s-1] = ~c[s-1];
        d = '0;
        k = 0;
        for (int p = 1; p <= 15; p++)
            if ((p & (p - 1)) != 0) begin d[k] = c[p-1]; k++; end
        return d;
    endfunction

    function automatic logic [10:0] gd(input int i);
        return 11'(11'h123 + i * 341);
    endfunction

    always_comb begin
        dec_syn  = syn(dec_cw);
        dec_data = ext(dec_cw);
    end
    assign enc_cw        = enc(enc_data);
    assign mif.mem_grant = grant;
    assign mif.mem_rdata = rdata;

    always @(posedge clk) begin
        if (load) for (int i = 0; i < 4; i++) mem[i] <= enc(gd(i));
        else if (inj) mem[inj_a] <= mem[inj_a] ^ inj_m;
        else if (mif.mem_req && mif.mem_grant && mif.mem_we) mem[mif.mem_addr] <= mif.mem_wdata;
        if (mif.mem_req && mif.mem_grant && !mif.mem_we) rdata <= mem[mif.mem_addr];
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic we, input logic [1:0] a);
        q.push_back('{we: we, a: a, d: we ? enc(gd(a)) : 15'd0});
    endtask

    task automatic wait_txns(input int n);
        int i;
        for (i = 0; i < 500 && q.size() > n; i++) tick();
        if (q.size() > n) begin
            checks++;
            errors++;
            $display("FAIL wait_txns: %0d pending, want <= %0d", q.size(), n);
            q.delete();
        end
    endtask

    task automatic wait_req(input logic we);
        int i;
        for (i = 0; i < 100 && !(mif.mem_req && mif.mem_we == we); i++) tick();
        chk("wait_req", {31'd0, mif.mem_req && mif.mem_we == we}, 32'd1);
    endtask

    task automatic stop_settle();
        enable = 1'b0;
        repeat (8) tick();
        chk("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic corrupt(input logic [1:0] a, input logic [14:0] m);
        inj_a = a;
        inj_m = m;
        inj = 1'b1;
        tick();
        inj = 1'b0;
    endtask

    task automatic do_reset();
        enable = 1'b0;
        grant = 1'b1;
        rst_n = 1'b0;
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        txn_t e;
        fork
            forever begin
                @(negedge clk);
                if (rst_n && mif.mem_req && mif.mem_grant) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_txn: we=%0d addr=%0d", mif.mem_we, mif.mem_addr);
                    end else begin
                        e = q.pop_front();
                        chk("txn_we", {31'd0, mif.mem_we}, {31'd0, e.we});
                        chk("txn_addr", {30'd0, mif.mem_addr}, {30'd0, e.a});
                        if (e.we) chk("txn_wdata", {17'd0, mif.mem_wdata}, {17'd0, e.d});
                    end
                    if (!mif.mem_we) last_rd = mif.mem_addr;
                end
                if (rst_n && pass_done) begin
                    pd_cnt++;
                    chk("pass_done_addr", {30'd0, last_rd}, 32'd3);
                end
            end
        join_none

        // reset state and clean walk
        do_reset();
        chk("rst_req", {31'd0, mif.mem_req}, 32'd0);
        chk("rst_we", {31'd0, mif.mem_we}, 32'd0);
        chk("rst_addr", {30'd0, mif.mem_addr}, 32'd0);
        chk("rst_wdata", {17'd0, mif.mem_wdata}, 32'd0);
        chk("rst_dec_cw", {17'd0, dec_cw}, 32'd0);
        chk("rst_enc_data", {21'd0, enc_data}, 32'd0);
        chk("rst_pass_done", {31'd0, pass_done}, 32'd0);
        chk("rst_corr", {30'd0, corr_cnt}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        pd_cnt = 0;
        push(0, 0); push(0, 1); push(0, 2); push(0, 3); push(0, 0);
        enable = 1'b1;
        wait_txns(0);
        stop_settle();
        chk("t1_pass_cnt", pd_cnt, 32'd1);
        chk("t1_corr", {30'd0, corr_cnt}, 32'd0);

        // single-bit error at addr 1, bit 5 -> syndrome 6
        do_reset();
        corrupt(2'd1, 15'h0020);
        push(0, 0); push(0, 1); push(1, 1); push(0, 2); push(0, 3); push(0, 0); push(0, 1);
        enable = 1'b1;
        wait_txns(0);
        stop_settle();
        chk("t2_corr", {30'd0, corr_cnt}, 32'd1);
        chk("t2_mem1", {17'd0, mem[1]}, {17'd0, enc(gd(1))});

        // grant held low for 10 cycles during read request
        do_reset();
        grant = 1'b0;
        enable = 1'b1;
        wait_req(1'b0);
        for (int i = 0; i < 10; i++) begin
            chk("t3_req", {31'd0, mif.mem_req}, 32'd1);
            chk("t3_we", {31'd0, mif.mem_we}, 32'd0);
            chk("t3_addr", {30'd0, mif.mem_addr}, 32'd0);
            tick();
        end
        push(0, 0);
        grant = 1'b1;
        wait_txns(0);
        stop_settle();
        chk("t3_corr", {30'd0, corr_cnt}, 32'd0);

        // enable dropped in CHECK with syndrome 3
        do_reset();
        corrupt(2'd2, 15'h0004);
        push(0, 0); push(0, 1); push(0, 2); push(1, 2);
        enable = 1'b1;
        wait_txns(1);
        tick();
        chk("t4_syn", {28'd0, dec_syn}, 32'd3);
        enable = 1'b0;
        wait_txns(0);
        repeat (8) tick();
        chk("t4_idle", {31'd0, busy}, 32'd0);
        chk("t4_corr", {30'd0, corr_cnt}, 32'd1);
        push(0, 3); push(0, 0);
        enable = 1'b1;
        wait_txns(0);
        stop_settle();

        // async reset while in write request
        do_reset();
        corrupt(2'd0, 15'h0100);
        push(0, 0); push(1, 0);
        enable = 1'b1;
        wait_txns(1);
        grant = 1'b0;
        wait_req(1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_req_async", {31'd0, mif.mem_req}, 32'd0);
        chk("t5_busy_async", {31'd0, busy}, 32'd0);
        q.delete();
        enable = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("t5_corr", {30'd0, corr_cnt}, 32'd0);
        chk("t5_addr", {30'd0, mif.mem_addr}, 32'd0);
        grant = 1'b1;
        push(0, 0); push(1, 0);
        enable = 1'b1;
        wait_txns(0);
        stop_settle();
        chk("t5_corr_after", {30'd0, corr_cnt}, 32'd1);

        // counter saturation: 5 errors into a 2-bit counter
        do_reset();
        corrupt(2'd0, 15'h0001);
        corrupt(2'd1, 15'h0008);
        corrupt(2'd2, 15'h0080);
        corrupt(2'd3, 15'h4000);
        for (int a = 0; a < 4; a++) begin push(0, 2'(a)); push(1, 2'(a)); end
        enable = 1'b1;
        wait_txns(0);
        stop_settle();
        chk("t6_corr4", {30'd0, corr_cnt}, 32'd3);
        corrupt(2'd0, 15'h0400);
        push(0, 0); push(1, 0);
        enable = 1'b1;
        wait_txns(0);
        stop_settle();
        chk("t6_corr5", {30'd0, corr_cnt}, 32'd3);
        chk("t6_mem0", {17'd0, mem[0]}, {17'd0, enc(gd(0))});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
